// File: rtl/buffer_read_drain.sv
// Read-side drain: pulls one PAR_READ-entry group from the circular buffer when
// available and serialises it, oldest entry first, onto a valid/ready stream.
module buffer_read_drain #(
   parameter int SIZE     = 8,
   parameter int PAR_READ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rd_ok,
   input  logic [PAR_READ*SIZE-1:0]   rd_data,
   output logic                       rd_en,
   output logic [SIZE-1:0]            out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic                       busy,
   output logic [15:0]                group_cnt
);

   localparam int W = PAR_READ * SIZE;
   localparam logic [2:0] LAST_IDX = 3'(PAR_READ - 1);

   // Handshake: an entry transfers on any edge where out_valid && out_ready;
   // out_data/out_last never change while out_valid is high and out_ready is low.

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         state;
   logic [W-1:0]   sh;
   logic [2:0]     idx;
   logic [15:0]    grp_q;
   logic           fire;
   logic           load;

   assign out_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign out_last  = (state == SHIFT) && (idx == LAST_IDX);
   assign out_data  = sh[W-1 -: SIZE];
   assign group_cnt = grp_q;

   assign fire = out_valid && out_ready;

   // rst gating keeps the read counter still while the drain is held in reset.
   assign load  = !rst && rd_ok && ((state == IDLE) || (fire && out_last));
   assign rd_en = load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sh    <= '0;
         idx   <= '0;
         grp_q <= '0;
      end else begin
         if (fire && out_last) begin
            grp_q <= grp_q + 16'd1;
         end
         if (load) begin
            // rd_data is captured before the pointer moves on this same edge.
            sh    <= rd_data;
            idx   <= '0;
            state <= SHIFT;
         end else if (fire) begin
            if (out_last) begin
               state <= IDLE;
            end else begin
               sh  <= sh << SIZE;
               idx <= idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_buffer_read_drain.sv
// Bench for buffer_read_drain: vector table, multi-cycle sequences, scoreboard
// on the PAR_READ=4 instance and a long counter-wrap run on a PAR_READ=1 instance.
module tb_buffer_read_drain;

   logic        clk;
   logic        rst;
   logic        rd_ok;
   logic [31:0] rd_data;
   logic        rd_en;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic [15:0] group_cnt;

   logic        rd_ok1;
   logic [7:0]  rd_data1;
   logic        rd_en1;
   logic [7:0]  out_data1;
   logic        out_valid1;
   logic        out_ready1;
   logic        out_last1;
   logic        busy1;
   logic [15:0] group_cnt1;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];

   typedef struct {
      logic        rd_ok;
      logic        rdy;
      logic [31:0] data;
      logic        e_rd_en;
      logic        e_valid;
      logic        e_last;
      logic        e_busy;
      logic        cd;
      logic [7:0]  e_data;
   } vec_t;

   vec_t vecs[$];

   buffer_read_drain #(.SIZE(8), .PAR_READ(4)) u0 (
      .clk(clk), .rst(rst), .rd_ok(rd_ok), .rd_data(rd_data), .rd_en(rd_en),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .group_cnt(group_cnt)
   );

   buffer_read_drain #(.SIZE(8), .PAR_READ(1)) u1 (
      .clk(clk), .rst(rst), .rd_ok(rd_ok1), .rd_data(rd_data1), .rd_en(rd_en1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_last(out_last1), .busy(busy1), .group_cnt(group_cnt1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_group(input logic [31:0] d);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({(i == 3), d[(3-i)*8 +: 8]});
      end
   endtask

   task automatic add(input logic ok, input logic rdy, input logic [31:0] d,
                      input logic e_en, input logic e_v, input logic e_l,
                      input logic e_b, input logic cd, input logic [7:0] e_d);
      vec_t v;
      v.rd_ok = ok; v.rdy = rdy; v.data = d; v.e_rd_en = e_en; v.e_valid = e_v;
      v.e_last = e_l; v.e_busy = e_b; v.cd = cd; v.e_data = e_d;
      vecs.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // scoreboard on the PAR_READ=4 instance
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_entry", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("sb_data", {24'd0, out_data}, {24'd0, e[7:0]});
            chk("sb_last", {31'd0, out_last}, {31'd0, e[8]});
         end
      end
   end

   initial begin
      logic [31:0] da;
      logic [7:0]  held;
      int n, pulses, bad_last, bad_dat;

      da = 32'hA1B2C3D4;
      // single group
      add(1, 1, da, 1, 0, 0, 0, 1, 8'h00);
      add(0, 1, da, 0, 1, 0, 1, 1, 8'hA1);
      add(0, 1, da, 0, 1, 0, 1, 1, 8'hB2);
      add(0, 1, da, 0, 1, 0, 1, 1, 8'hC3);
      add(0, 1, da, 0, 1, 1, 1, 1, 8'hD4);
      add(0, 1, da, 0, 0, 0, 0, 0, 8'h00);
      // backpressure, ready pattern 1,0,0,1,1,0,1
      add(1, 1, da, 1, 0, 0, 0, 0, 8'h00);
      add(0, 1, da, 0, 1, 0, 1, 1, 8'hA1);
      add(0, 0, da, 0, 1, 0, 1, 1, 8'hB2);
      add(0, 0, da, 0, 1, 0, 1, 1, 8'hB2);
      add(0, 1, da, 0, 1, 0, 1, 1, 8'hB2);
      add(0, 1, da, 0, 1, 0, 1, 1, 8'hC3);
      add(0, 0, da, 0, 1, 1, 1, 1, 8'hD4);
      add(0, 1, da, 0, 1, 1, 1, 1, 8'hD4);
      add(0, 1, da, 0, 0, 0, 0, 0, 8'h00);

      rst = 1'b1; rd_ok = 1'b1; rd_data = da; out_ready = 1'b1;
      rd_ok1 = 1'b0; rd_data1 = 8'h00; out_ready1 = 1'b1;
      next_cycle();
      chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_gcnt", {16'd0, group_cnt}, 32'd0);
      rd_ok = 1'b0;
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // table-driven vectors
      push_group(da);
      push_group(da);
      foreach (vecs[i]) begin
         rd_ok = vecs[i].rd_ok; out_ready = vecs[i].rdy; rd_data = vecs[i].data;
         @(negedge clk);
         chk($sformatf("vec%0d_rd_en", i), {31'd0, rd_en}, {31'd0, vecs[i].e_rd_en});
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d_last", i), {31'd0, out_last}, {31'd0, vecs[i].e_last});
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
         if (vecs[i].cd) begin
            chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_data});
         end
         next_cycle();
      end
      chk("table_gcnt", {16'd0, group_cnt}, 32'd2);
      chk("table_sb_drained", exp_q.size(), 32'd0);

      // back-to-back groups with rd_ok held high
      push_group(32'h00010203);
      push_group(32'h04050607);
      for (int c = 0; c < 9; c++) begin
         rd_ok = (c < 8); out_ready = 1'b1;
         rd_data = (c < 4) ? 32'h00010203 : 32'h04050607;
         @(negedge clk);
         chk($sformatf("b2b%0d_rd_en", c), {31'd0, rd_en}, {31'd0, (c == 0 || c == 4)});
         chk($sformatf("b2b%0d_valid", c), {31'd0, out_valid}, {31'd0, (c >= 1 && c <= 8)});
         next_cycle();
      end
      chk("b2b_gcnt", {16'd0, group_cnt}, 32'd4);
      chk("b2b_idle", {31'd0, out_valid}, 32'd0);

      // starvation, then a late rd_ok
      rd_ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         rd_data = $urandom_range(0, 32'hFFFF);
         @(negedge clk);
         chk($sformatf("starve%0d_rd_en", c), {31'd0, rd_en}, 32'd0);
         chk($sformatf("starve%0d_valid", c), {31'd0, out_valid}, 32'd0);
         next_cycle();
      end
      rd_ok = 1'b1; rd_data = 32'h5A6B7C8D;
      push_group(32'h5A6B7C8D);
      @(negedge clk);
      chk("starve_rd_en_edge", {31'd0, rd_en}, 32'd1);
      chk("starve_valid_edge", {31'd0, out_valid}, 32'd0);
      next_cycle();
      rd_ok = 1'b0; rd_data = 32'h0;
      @(negedge clk);
      chk("starve_first_valid", {31'd0, out_valid}, 32'd1);
      for (int c = 0; c < 5; c++) next_cycle();
      chk("starve_gcnt", {16'd0, group_cnt}, 32'd5);
      chk("starve_sb_drained", exp_q.size(), 32'd0);

      // reset after B2 is accepted
      rd_ok = 1'b1; rd_data = 32'h11223344; out_ready = 1'b1;
      push_group(32'h11223344);
      next_cycle();
      rd_ok = 1'b0;
      next_cycle();
      next_cycle();
      #2;
      rst = 1'b1; rd_ok = 1'b1;
      #1;
      exp_q.delete();
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("midrst_last", {31'd0, out_last}, 32'd0);
      chk("midrst_gcnt", {16'd0, group_cnt}, 32'd0);
      next_cycle();
      rd_ok = 1'b0;
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("postrst%0d_valid", c), {31'd0, out_valid}, 32'd0);
         chk($sformatf("postrst%0d_rd_en", c), {31'd0, rd_en}, 32'd0);
         chk($sformatf("postrst%0d_busy", c), {31'd0, busy}, 32'd0);
         next_cycle();
      end

      // PAR_READ=1 wrap run
      n = 0; pulses = 0; bad_last = 0; bad_dat = 0; held = 8'h00;
      rd_ok1 = 1'b1; out_ready1 = 1'b1;
      for (int c = 0; c < 75000 && n < 70000; c++) begin
         rd_data1 = 8'($urandom_range(0, 255));
         @(negedge clk);
         if (out_valid1 && out_ready1) begin
            n++;
            if (out_last1 !== 1'b1) bad_last++;
            if (out_data1 !== held) bad_dat++;
         end
         if (n == 70000) rd_ok1 = 1'b0;
         #1;
         if (rd_en1) begin
            pulses++;
            held = rd_data1;
         end
         next_cycle();
      end
      chk("wrap_entries", n, 32'd70000);
      chk("wrap_rd_en_pulses", pulses, 32'd70000);
      chk("wrap_last_misses", bad_last, 32'd0);
      chk("wrap_data_misses", bad_dat, 32'd0);
      chk("wrap_gcnt", {16'd0, group_cnt1}, 32'd4464);
      chk("wrap_idle", {31'd0, out_valid1}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
